// File: rtl/enigma_pkg.sv
// enigma_pkg: symbol constants, legality check and controller state encoding
// shared by the message controller and its output FIFO.
package enigma_pkg;
    localparam int SYMB_W   = 7;
    localparam int SYMB_MIN = 1;
    localparam int SYMB_MAX = 26;

    typedef enum logic [2:0] {IDLE, CRST, RUN, DRAIN, DONE} ctrl_state_t;

    function automatic logic symb_legal(input logic [SYMB_W-1:0] s);
        return (s >= SYMB_W'(SYMB_MIN)) && (s <= SYMB_W'(SYMB_MAX));
    endfunction
endpackage

// File: rtl/enigma_ctrl_fifo.sv
// enigma_ctrl_fifo: synchronous symbol FIFO with occupancy count; head reads as 0 when empty.
module enigma_ctrl_fifo
    import enigma_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en,
    input  logic [SYMB_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [SYMB_W-1:0] rd_data,
    output logic              empty,
    output logic [AW:0]       count
);
    logic [SYMB_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign empty   = count == '0;
    assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/enigma_msg_ctrl.sv
// enigma_msg_ctrl: re-initialises an enigma_1 core, streams a message into it and buffers ciphertext.
// Defining ENIGMA_CTRL_STATS_EN adds drop_cnt_o, the per-message count of dropped illegal symbols.
module enigma_msg_ctrl
    import enigma_pkg::*;
#(
    parameter int LEN_W     = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  msg_len_i,
    input  logic              s_valid_i,
    input  logic [SYMB_W-1:0] s_symb_i,
    output logic              s_ready_o,
    output logic              m_valid_o,
    output logic [SYMB_W-1:0] m_symb_o,
    input  logic              m_ready_i,
    output logic              core_rst_n_o,
    output logic [SYMB_W-1:0] core_symb_o,
    input  logic [SYMB_W-1:0] core_symb_i,
    output logic              busy_o,
    output logic              done_o,
`ifdef ENIGMA_CTRL_STATS_EN
    output logic [LEN_W-1:0]  drop_cnt_o,
`endif
    output logic              err_o
);
    localparam int CW = $clog2(OUT_DEPTH);

    ctrl_state_t      state, state_nxt;
    logic [LEN_W-1:0] cnt, len;
    logic             v1, v2;
    logic [1:0]       inflight;
    logic [CW:0]      fifo_count;
    logic             fifo_empty, accept, legal, start;

    // v1: legal symbol on core_symb_o; v2: core output valid, written to the FIFO next edge
    assign inflight  = {1'b0, v1} + {1'b0, v2};
    assign legal     = symb_legal(s_symb_i);
    assign start     = (state == IDLE) && start_i;
    assign s_ready_o = (state == RUN) && (cnt != len) &&
                       (({1'b0, fifo_count} + (CW+2)'(inflight)) < (CW+2)'(OUT_DEPTH));
    assign accept    = s_valid_i && s_ready_o;
    assign m_valid_o = !fifo_empty;
    assign busy_o    = state != IDLE;
    assign done_o    = state == DONE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start_i ? CRST : IDLE;
            CRST:    state_nxt = RUN;
            RUN:     state_nxt = (cnt + LEN_W'(accept) == len) ? DRAIN : RUN;
            DRAIN:   state_nxt = (inflight == 2'd0 && fifo_empty) ? DONE : DRAIN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            len          <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            core_symb_o  <= '0;
            core_rst_n_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_nxt;
            core_rst_n_o <= state_nxt != CRST;
            core_symb_o  <= (accept && legal) ? s_symb_i : '0;
            v1           <= accept && legal;
            v2           <= v1;
            if (start) begin
                cnt   <= '0;
                len   <= msg_len_i;
                err_o <= 1'b0;
            end else begin
                if (accept) cnt <= cnt + LEN_W'(1);
                if (accept && !legal) err_o <= 1'b1;
            end
        end
    end

`ifdef ENIGMA_CTRL_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) drop_cnt_o <= '0;
        else if (start) drop_cnt_o <= '0;
        else if (accept && !legal && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + LEN_W'(1);
    end
`endif

    // slots for inflight symbols are reserved through s_ready_o, so writes never hit a full FIFO
    enigma_ctrl_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (v2),
        .wr_data (core_symb_i),
        .rd_en   (m_valid_o && m_ready_i),
        .rd_data (m_symb_o),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_enigma_msg_ctrl.sv
// tb_enigma_msg_ctrl: table-driven and randomized checks of enigma_msg_ctrl around a
// behavioural stand-in core (stepping, reciprocal, fixed-point-free substitution).
module tb_enigma_msg_ctrl;
    localparam int LEN_W     = 8;
    localparam int OUT_DEPTH = 4;

    logic             clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
    logic             s_valid_i = 1'b0, m_ready_i = 1'b0;
    logic [LEN_W-1:0] msg_len_i = '0;
    logic [6:0]       s_symb_i = '0;
    logic             s_ready_o, m_valid_o, core_rst_n_o, busy_o, done_o, err_o;
    logic [6:0]       m_symb_o, core_symb_o, core_symb_i;
`ifdef ENIGMA_CTRL_STATS_EN
    logic [LEN_W-1:0] drop_cnt_o;
`endif

    int n_cmp = 0, n_bad = 0;
    logic [6:0] stim[$], got[$], pt[$];

    always #5 clk_i = ~clk_i;

    enigma_msg_ctrl #(.LEN_W(LEN_W), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .msg_len_i(msg_len_i),
        .s_valid_i(s_valid_i), .s_symb_i(s_symb_i), .s_ready_o(s_ready_o),
        .m_valid_o(m_valid_o), .m_symb_o(m_symb_o), .m_ready_i(m_ready_i),
        .core_rst_n_o(core_rst_n_o), .core_symb_o(core_symb_o), .core_symb_i(core_symb_i),
        .busy_o(busy_o), .done_o(done_o),
`ifdef ENIGMA_CTRL_STATS_EN
        .drop_cnt_o(drop_cnt_o),
`endif
        .err_o(err_o)
    );

    function automatic bit legal(input logic [6:0] s);
        return s >= 7'd1 && s <= 7'd26;
    endfunction

    // k-th legal symbol of a message: rotate by k, swap adjacent pair, rotate back
    function automatic logic [6:0] cipher(input int x, input int k);
        int y, z;
        y = (x - 1 + k) % 26;
        z = y ^ 1;
        return 7'(((z - (k % 26) + 26) % 26) + 1);
    endfunction

    int core_pos;
    always_ff @(posedge clk_i or negedge core_rst_n_o) begin
        if (!core_rst_n_o) begin
            core_pos    <= 0;
            core_symb_i <= '0;
        end else if (legal(core_symb_o)) begin
            core_symb_i <= cipher(core_symb_o, core_pos);
            core_pos    <= core_pos + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"}, s_ready_o, 0);
        check({tag, "_m_valid"}, m_valid_o, 0);
        check({tag, "_m_symb"}, m_symb_o, 0);
        check({tag, "_core_rst_n"}, core_rst_n_o, 0);
        check({tag, "_core_symb"}, core_symb_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
`ifdef ENIGMA_CTRL_STATS_EN
        check({tag, "_drop_cnt"}, drop_cnt_o, 0);
`endif
    endtask

    // mode 0: back-to-back, ready=1; mode 1: random valid/ready; mode 2: ready held low for `hold` cycles
    task automatic run_msg(input int len, input int mode, input int hold, input int exp_out, input int exp_err);
        logic [6:0] exp_q[$], plain_q[$];
        int k = 0, drops = 0, idx = 0, dones = 0, cyc = 0, done_cyc = -1;
        int first_acc = -1, first_mv = -1, held_acc = 0;
        bit fin = 0;
        for (int i = 0; i < len; i++) begin
            if (legal(stim[i])) begin
                exp_q.push_back(cipher(stim[i], k));
                plain_q.push_back(stim[i]);
                k++;
            end else drops++;
        end
        got.delete();
        @(negedge clk_i);
        start_i   = 1'b1;
        msg_len_i = LEN_W'(len);
        @(negedge clk_i);
        start_i   = 1'b0;
        msg_len_i = LEN_W'($urandom_range(0, 255));
        check("crst_low", core_rst_n_o, 0);
        check("crst_busy", busy_o, 1);
        check("crst_err_clr", err_o, 0);
        for (cyc = 0; cyc < 300 + len * 30 && !fin; cyc++) begin
            s_valid_i = (idx < len) && (mode != 1 || $urandom_range(0, 2) != 0);
            s_symb_i  = (idx < len) ? stim[idx] : 7'($urandom_range(0, 127));
            m_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : !(mode == 2 && cyc < hold);
            #1;
            if (cyc == 1) check("crst_one_cycle", core_rst_n_o, 1);
            if (s_valid_i && s_ready_o) begin
                if (legal(stim[idx]) && first_acc < 0) first_acc = cyc;
                if (!m_ready_i) held_acc++;
                idx++;
            end
            if (m_valid_o && first_mv < 0) first_mv = cyc;
            if (m_valid_o && m_ready_i) got.push_back(m_symb_o);
            if (done_o) begin
                dones++;
                done_cyc = cyc;
                fin = 1;
            end
            @(negedge clk_i);
        end
        s_valid_i = 1'b0;
        check("done_seen", fin, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            if (done_o) dones++;
            @(negedge clk_i);
        end
        check("done_once", dones, 1);
        check("busy_after", busy_o, 0);
        check("accepted", idx, len);
        check("out_count", got.size(), exp_q.size());
        if (exp_out >= 0) check("out_count_tbl", got.size(), exp_out);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check("out_symb", got[i], exp_q[i]);
            check("not_identity", got[i] != plain_q[i], 1);
        end
        check("err", err_o, drops > 0);
        if (exp_err >= 0) check("err_tbl", err_o, exp_err);
`ifdef ENIGMA_CTRL_STATS_EN
        check("drop_cnt", drop_cnt_o, drops);
`endif
        if (first_acc >= 0) check("first_valid_latency", first_mv - first_acc, 3);
        if (mode == 2) check("held_accepts", held_acc, OUT_DEPTH);
        if (len == 0) begin
            check("len0_done_by_4", done_cyc <= 3, 1);
            check("len0_no_valid", first_mv, -1);
        end
    endtask

    typedef struct {
        int len;
        int mode;
        int exp_out;
        int exp_err;
    } vec_t;

    vec_t       vt[5];
    logic [6:0] tsym[5][8];

    initial begin
        int n;
        vt[0] = '{5, 0, 5, 0};  tsym[0] = '{1, 2, 3, 4, 5, 0, 0, 0};
        vt[1] = '{4, 0, 2, 1};  tsym[1] = '{3, 0, 30, 7, 0, 0, 0, 0};
        vt[2] = '{0, 0, 0, 0};  tsym[2] = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[3] = '{3, 0, 2, 1};  tsym[3] = '{26, 1, 127, 0, 0, 0, 0, 0};
        vt[4] = '{6, 1, 6, 0};  tsym[4] = '{26, 25, 1, 2, 13, 14, 0, 0};

        #1 rst_i = 1'b0;
        #1 check_reset("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int v = 0; v < 5; v++) begin
            stim.delete();
            for (int i = 0; i < vt[v].len; i++) stim.push_back(tsym[v][i]);
            run_msg(vt[v].len, vt[v].mode, 0, vt[v].exp_out, vt[v].exp_err);
        end

        // encrypt then decrypt with a freshly re-initialised core
        stim = '{7'd8, 7'd5, 7'd12, 7'd12, 7'd15, 7'd23, 7'd15, 7'd18};
        pt = stim;
        run_msg(8, 0, 0, 8, 0);
        stim = got;
        run_msg(8, 0, 0, 8, 0);
        for (int i = 0; i < 8; i++) check("roundtrip", (i < got.size()) ? got[i] : 7'd0, pt[i]);

        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back(7'($urandom_range(1, 26)));
        run_msg(10, 2, 15, 10, 0);

        // asynchronous reset mid-message
        stim = '{7'd5, 7'd0, 7'd9, 7'd11, 7'd12, 7'd13};
        m_ready_i = 1'b0;
        @(negedge clk_i);
        start_i   = 1'b1;
        msg_len_i = 8'd6;
        @(negedge clk_i);
        start_i   = 1'b0;
        s_valid_i = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            s_symb_i = stim[n];
            #1;
            if (s_ready_o) n++;
            @(negedge clk_i);
        end
        s_valid_i = 1'b0;
        check("mid_accepts", n, 3);
        repeat (3) @(negedge clk_i);
        check("pre_rst_valid", m_valid_o, 1);
        check("pre_rst_err", err_o, 1);
        rst_i = 1'b0;
        #1 check_reset("mid_reset");
        @(negedge clk_i);
        rst_i = 1'b1;
        stim = '{7'd20, 7'd21, 7'd22};
        run_msg(3, 0, 0, 3, 0);

        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 20);
            stim.delete();
            for (int i = 0; i < len; i++)
                stim.push_back(($urandom_range(0, 4) != 0) ? 7'($urandom_range(1, 26)) : 7'($urandom_range(0, 127)));
            run_msg(len, 1, 0, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
